// File: rtl/crc_pkg.sv
// Shared opcodes, FSM state type and bit-level CRC helpers for the CRC engine.
package crc_pkg;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_FEED1  = 3'd1;
  localparam logic [2:0] OP_FEED2  = 3'd2;
  localparam logic [2:0] OP_FEED3  = 3'd3;
  localparam logic [2:0] OP_FEED4  = 3'd4;
  localparam logic [2:0] OP_FEED8  = 3'd5;
  localparam logic [2:0] OP_READ   = 3'd6;
  localparam logic [2:0] OP_SELECT = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // Reverse the low w bits of x; bits at and above w come out zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] x, input int w);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = x;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], s[0]};
        s = {1'b0, s[31:1]};
      end
    end
    return r;
  endfunction

  // Fold one byte into a w-bit CRC held in the low bits of crc.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc, input logic [7:0] b,
                                                input logic [31:0] poly, input logic reflect,
                                                input int w);
    logic [31:0] mask;
    logic [31:0] top;
    logic [31:0] rp;
    logic [31:0] c;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    top  = 32'd1 << (w - 1);
    rp   = bit_reverse(poly & mask, w);
    if (reflect) begin
      c = (crc & mask) ^ {24'd0, b};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
    end else begin
      c = (crc & mask) ^ ({24'd0, b} << (w - 8));
      for (int k = 0; k < 8; k++)
        c = ((c & top) != 32'd0) ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
    end
    return c & mask;
  endfunction

endpackage

// File: rtl/crc_step_lane.sv
// Combinational fold of up to BPC bytes into a CRC; bytes with a clear mask bit pass through.
module crc_step_lane
  import crc_pkg::*;
#(
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C1_1DB7,
  parameter bit          REFLECT = 1'b1,
  parameter int          BPC     = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BPC*8-1:0] data,
  input  logic [BPC-1:0]   vmask,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] chain [BPC+1];

  assign chain[0] = crc_in;

  // Byte j is folded after bytes 0..j-1; lowest byte first.
  for (genvar j = 0; j < BPC; j++) begin : g_byte
    assign chain[j+1] = vmask[j]
      ? CRC_W'(crc_byte_step(32'(chain[j]), data[j*8 +: 8], POLY, REFLECT, CRC_W))
      : chain[j];
  end

  assign crc_out = chain[BPC];

endmodule

// File: rtl/crc_multi_ci.sv
// Multi-context CRC custom instruction: start/done handshake, byte-serial fold per context.
module crc_multi_ci
  import crc_pkg::*;
#(
  parameter int          CRC_W           = 32,
  parameter logic [31:0] POLY            = 32'h04C1_1DB7,
  parameter logic [31:0] INIT            = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT          = 32'hFFFF_FFFF,
  parameter bit          REFLECT         = 1'b1,
  parameter int          BYTES_PER_CYCLE = 1,
  parameter int          NUM_CH          = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  output logic        done,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [2:0]  n,
  output logic [31:0] result
);

  localparam int         BPC   = BYTES_PER_CYCLE;
  localparam int         CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] BPC_C = 4'(BPC);

  state_t                       state, state_nx;
  logic [2:0]                   op;
  logic [63:0]                  shreg;
  logic [3:0]                   rem;
  logic [NUM_CH-1:0][CRC_W-1:0] ctx;
  logic [CRC_W-1:0]             acc, lane_out;
  logic [CH_W-1:0]              cur_ch;
  logic                         err;
  logic [31:0]                  res_q, res_nx;
  logic [BPC-1:0]               vmask;
  logic                         accept, collide, is_feed, last, finish;

  assign accept  = clk_en & start & (state == ST_IDLE);
  assign collide = clk_en & start & (state != ST_IDLE);
  assign is_feed = (op >= OP_FEED1) && (op <= OP_FEED8);
  // Non-feed ops and the final (possibly partial) feed step both finish this cycle.
  assign last    = !is_feed || (rem <= BPC_C);
  assign finish  = clk_en && (state == ST_RUN) && last;

  function automatic logic [3:0] op_bytes(input logic [2:0] o);
    if (o >= OP_FEED1 && o <= OP_FEED4) return 4'(o);
    if (o == OP_FEED8) return 4'd8;
    return 4'd0;
  endfunction

  for (genvar j = 0; j < BPC; j++) begin : g_mask
    assign vmask[j] = (rem > 4'(j));
  end

  crc_step_lane #(
    .CRC_W(CRC_W), .POLY(POLY), .REFLECT(REFLECT), .BPC(BPC)
  ) u_lane (
    .crc_in (acc),
    .data   (shreg[BPC*8-1:0]),
    .vmask  (vmask),
    .crc_out(lane_out)
  );

  // Next state: a stalled cycle holds everything, including DONE.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (clk_en && last) state_nx = ST_DONE;
      ST_DONE: if (clk_en) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Result of the op completing this cycle.
  always_comb begin
    res_nx = '0;
    case (op)
      OP_LOAD:   res_nx = 32'(shreg[CRC_W-1:0]);
      OP_READ:   res_nx = 32'(ctx[cur_ch] ^ XOROUT[CRC_W-1:0]);
      OP_SELECT: res_nx = {err, 27'd0, 4'(cur_ch)};
      default:   res_nx = 32'(lane_out);
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Operand latch, byte counter, working CRC and held result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op    <= OP_LOAD;
      shreg <= '0;
      rem   <= '0;
      acc   <= '0;
      res_q <= '0;
    end else if (accept) begin
      op    <= n;
      shreg <= {datab, dataa};
      rem   <= op_bytes(n);
      acc   <= ctx[cur_ch];
    end else if (clk_en && state == ST_RUN) begin
      acc   <= lane_out;
      shreg <= shreg >> (8 * BPC);
      rem   <= last ? 4'd0 : rem - BPC_C;
      if (last) res_q <= res_nx;
    end
  end

  // Context file, channel pointer and sticky collision flag; a ctx changes only at its op's end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctx    <= {NUM_CH{INIT[CRC_W-1:0]}};
      cur_ch <= '0;
      err    <= 1'b0;
    end else begin
      if (finish) begin
        case (op)
          OP_LOAD: ctx[cur_ch] <= shreg[CRC_W-1:0];
          OP_READ: ;
          OP_SELECT: begin
            if (NUM_CH > 1) cur_ch <= shreg[CH_W-1:0];
            err <= 1'b0;
          end
          default: ctx[cur_ch] <= lane_out;
        endcase
      end
      if (collide) err <= 1'b1;
    end
  end

  assign done   = (state == ST_DONE) & clk_en;
  assign result = done ? res_q : 32'd0;

endmodule

// File: tb/tb_crc_multi_ci.sv
// Bench: three engines (1, 4 and 2 bytes/cycle) share one command stream and are checked
// against a table-driven CRC-32 model with a cycle-level latency expectation.
module tb_crc_multi_ci;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic [2:0]  n;
  logic [ND-1:0] done;
  logic [31:0] result [ND];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] m_ctx [4];
  int          m_ch;
  logic        m_err;
  logic [31:0] tbl [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_multi_ci #(.BYTES_PER_CYCLE(1)) u0 (.clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .done(done[0]), .dataa(dataa), .datab(datab), .n(n), .result(result[0]));
  crc_multi_ci #(.BYTES_PER_CYCLE(4)) u1 (.clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .done(done[1]), .dataa(dataa), .datab(datab), .n(n), .result(result[1]));
  crc_multi_ci #(.BYTES_PER_CYCLE(2)) u2 (.clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .done(done[2]), .dataa(dataa), .datab(datab), .n(n), .result(result[2]));

  function automatic int bpc_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 2;
  endfunction

  function automatic int steps_of(input int op, input int bpc);
    int nb;
    nb = (op >= 1 && op <= 4) ? op : (op == 5) ? 8 : 0;
    return (nb == 0) ? 1 : (nb + bpc - 1) / bpc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_feed(input logic [7:0] b);
    logic [7:0] ix;
    ix = m_ctx[m_ch][7:0] ^ b;
    m_ctx[m_ch] = (m_ctx[m_ch] >> 8) ^ tbl[ix];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ctx[i] = 32'hFFFF_FFFF;
    m_ch  = 0;
    m_err = 1'b0;
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r);
    logic [63:0] bytes_q;
    bytes_q = {b, a};
    r = '0;
    case (op)
      3'd0: begin m_ctx[m_ch] = a; r = a; end
      3'd1, 3'd2, 3'd3, 3'd4: begin
        for (int k = 0; k < int'(op); k++) m_feed(8'(bytes_q >> (8 * k)));
        r = m_ctx[m_ch];
      end
      3'd5: begin
        for (int k = 0; k < 8; k++) m_feed(8'(bytes_q >> (8 * k)));
        r = m_ctx[m_ch];
      end
      3'd6: r = m_ctx[m_ch] ^ 32'hFFFF_FFFF;
      default: begin
        r = {m_err, 27'd0, 4'(m_ch)};
        m_ch  = int'(a[1:0]);
        m_err = 1'b0;
      end
    endcase
  endtask

  // Issue one command; optional clk_en stall window and a colliding start at a cycle offset.
  task automatic cmd(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int st_off, input int st_len, input int co_off,
                     output logic [31:0] r0, output int l0, output int l1, output int l2);
    int          t, off, stray, c, cnt, expd;
    int          dcyc [ND];
    int          np [ND];
    logic [31:0] dres [ND];
    logic [31:0] exp_r;
    @(negedge clk);
    clk_en = 1'b1; start = 1'b1; n = op; dataa = a; datab = b;
    t = cyc;
    model_exec(op, a, b, exp_r);
    stray = 0;
    for (int i = 0; i < ND; i++) begin dcyc[i] = -1; np[i] = 0; dres[i] = '0; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      off    = cyc - t;
      clk_en = !(off >= st_off && off < st_off + st_len);
      start  = (off == co_off);
      if (start) begin n = 3'd0; dataa = $urandom; datab = $urandom; end
      #1;
      for (int i = 0; i < ND; i++) begin
        if (done[i]) begin
          np[i]++;
          if (dcyc[i] < 0) begin dcyc[i] = off; dres[i] = result[i]; end
        end else if (result[i] !== 32'd0) stray++;
      end
    end
    clk_en = 1'b1; start = 1'b0;
    if (co_off > 0) m_err = 1'b1;
    for (int i = 0; i < ND; i++) begin
      c = 1; cnt = 0; expd = -1;
      while (c < 40 && expd < 0) begin
        if (!(c >= st_off && c < st_off + st_len)) begin
          if (cnt == steps_of(int'(op), bpc_of(i))) expd = c;
          else cnt++;
        end
        c++;
      end
      chk($sformatf("%s_lat%0d", tag, i), dcyc[i], expd);
      chk($sformatf("%s_res%0d", tag, i), dres[i], exp_r);
      chk($sformatf("%s_pulses%0d", tag, i), np[i], 1);
    end
    chk({tag, "_quiet"}, stray, 0);
    r0 = dres[0]; l0 = dcyc[0]; l1 = dcyc[1]; l2 = dcyc[2];
  endtask

  initial begin
    logic [31:0] r, c32, a, b;
    int l0, l1, l2, t, op, so, sl, co;

    for (int i = 0; i < 256; i++) begin
      c32 = 32'(i);
      for (int k = 0; k < 8; k++) c32 = c32[0] ? ((c32 >> 1) ^ 32'hEDB8_8320) : (c32 >> 1);
      tbl[i] = c32;
    end
    model_reset();

    reset = 1'b0; clk_en = 1'b1; start = 1'b0; n = '0; dataa = '0; datab = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < ND; i++) chk($sformatf("rst_result%0d", i), result[i], 32'd0);
    reset = 1'b1;

    // check string "123456789" on ch0, plus the spec latencies
    cmd("t1_load", 3'd0, 32'hFFFF_FFFF, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t1_f4a", 3'd4, 32'h3433_3231, 0, -1, 0, -1, r, l0, l1, l2);
    chk("lat_feed4_b1", l0, 5);
    chk("lat_feed4_b4", l1, 2);
    cmd("t1_f4b", 3'd4, 32'h3837_3635, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t1_f1", 3'd1, 32'h0000_0039, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t1_read", 3'd6, 0, 0, -1, 0, -1, r, l0, l1, l2);
    chk("check_crc", r, 32'hCBF4_3926);

    // interleaved contexts ch0/ch2, untouched ch1
    cmd("t3_s0", 3'd7, 0, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_l0", 3'd0, 32'hFFFF_FFFF, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_a0", 3'd4, 32'h3433_3231, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_s2", 3'd7, 2, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_l2", 3'd0, 32'hFFFF_FFFF, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_a2", 3'd4, 32'h3433_3231, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_b2", 3'd5, 32'h3837_3635, 32'h0000_0039, -1, 0, -1, r, l0, l1, l2);
    chk("lat_feed8_b2", l2, 5);
    cmd("t3_s0b", 3'd7, 0, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_b0", 3'd4, 32'h3837_3635, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_c0", 3'd1, 32'h0000_0039, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_r0", 3'd6, 0, 0, -1, 0, -1, r, l0, l1, l2);
    chk("ch0_crc", r, 32'hCBF4_3926);
    cmd("t3_s2b", 3'd7, 2, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_r2", 3'd5, 0, 0, -1, 0, -1, r, l0, l1, l2);
    cmd("t3_s1", 3'd7, 1, 0, -1, 0, -1, r, l0, l1, l2);
    chk("sel_old_ch", r, 32'd2);
    cmd("t3_r1", 3'd6, 0, 0, -1, 0, -1, r, l0, l1, l2);
    chk("ch1_init", r, 32'd0);

    // busy collision during FEED8
    cmd("t4_f8", 3'd5, 32'h1122_3344, 32'h5566_7788, -1, 0, 2, r, l0, l1, l2);
    cmd("t4_sa", 3'd7, 1, 0, -1, 0, -1, r, l0, l1, l2);
    chk("err_set", 32'(r[31]), 32'd1);
    cmd("t4_sb", 3'd7, 1, 0, -1, 0, -1, r, l0, l1, l2);
    chk("err_clr", 32'(r[31]), 32'd0);

    // stall three cycles mid-FEED4
    cmd("t5_f4", 3'd4, 32'hDEAD_BEEF, 0, 2, 3, -1, r, l0, l1, l2);
    chk("lat_stall_b1", l0, 8);
    chk("lat_stall_b4", l1, 5);

    // reset in RUN of FEED8
    cmd("t6_s3", 3'd7, 3, 0, -1, 0, -1, r, l0, l1, l2);
    @(negedge clk);
    start = 1'b1; n = 3'd5; dataa = 32'hCAFE_F00D; datab = 32'h1234_5678; t = cyc;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_nodone%0d", k), 32'(done), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    model_reset();
    cmd("t6_read", 3'd6, 0, 0, -1, 0, -1, r, l0, l1, l2);
    chk("t6_read0", r, 32'd0);
    cmd("t6_sel", 3'd7, 0, 0, -1, 0, -1, r, l0, l1, l2);
    chk("t6_ch0", r, 32'd0);

    // randomized command stream
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 7);
      a  = $urandom;
      b  = $urandom;
      so = -1; sl = 0; co = -1;
      if ($urandom_range(0, 3) == 0) begin
        so = $urandom_range(1, 4);
        sl = $urandom_range(1, 3);
      end else if (op != 7 && $urandom_range(0, 7) == 0) begin
        co = 1;
      end
      cmd($sformatf("rnd%0d", it), 3'(op), a, b, so, sl, co, r, l0, l1, l2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
